// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO responder: default base address, register
// offsets within the 256-byte window and status register bit positions.
package mmio_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_RX     = 8'h04;
    localparam logic [7:0] OFF_TX     = 8'h08;
    localparam logic [7:0] OFF_CYC    = 8'h10;
    localparam logic [7:0] OFF_INST   = 8'h14;
    localparam logic [7:0] OFF_CLR    = 8'h18;
    localparam logic [7:0] OFF_BR     = 8'h1C;

    localparam int ST_TX_RDY = 0;
    localparam int ST_RX_VLD = 1;

endpackage

// File: rtl/mmio_counter.sv
// Free-running up-counter with increment enable; clear beats increment,
// and the synchronous reset beats both.
module mmio_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder: UART status/RX/TX registers and performance counters with a
// one-cycle registered read. Define MMIO_BRANCH_CTR_EN to add the branch counter.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
    parameter int          CTR_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we,
    input  logic        re,
    output logic [31:0] rdata,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic        inst_retire,
    input  logic        branch_retire
);

    logic                 hit;
    logic [7:0]           offset;
    logic                 load;
    logic                 store;
    logic                 ctr_clr;
    logic                 tx_push;
    logic [31:0]          read_mux;
    logic [31:0]          rdata_reg;
    logic                 tx_valid_reg;
    logic [7:0]           tx_data_reg;
    logic [CTR_WIDTH-1:0] cyc_count;
    logic [CTR_WIDTH-1:0] inst_count;
    logic                 unused_bits;

    assign hit     = (addr[31:8] == MMIO_BASE[31:8]);
    assign offset  = addr[7:0];
    assign load    = re && hit;
    assign store   = (|we) && hit;
    assign ctr_clr = store && (offset == OFF_CLR);
    assign tx_push = store && (offset == OFF_TX) && we[0];

    // The pop handshake happens on the same edge that captures the byte.
    assign uart_rx_ready = load && (offset == OFF_RX) && uart_rx_valid;

    mmio_counter #(.WIDTH(CTR_WIDTH)) u_cyc_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .clr   (ctr_clr),
        .count (cyc_count)
    );

    mmio_counter #(.WIDTH(CTR_WIDTH)) u_inst_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (inst_retire),
        .clr   (ctr_clr),
        .count (inst_count)
    );

`ifdef MMIO_BRANCH_CTR_EN
    logic [CTR_WIDTH-1:0] br_count;

    mmio_counter #(.WIDTH(CTR_WIDTH)) u_br_ctr (
        .clk   (clk),
        .rst   (rst),
        .inc   (branch_retire),
        .clr   (ctr_clr),
        .count (br_count)
    );

    assign unused_bits = ^wdata[31:8];
`else
    assign unused_bits = ^{wdata[31:8], branch_retire};
`endif

    // Counters are read before this edge's increment because they are sampled
    // from their registers, not from the next-state value.
    always_comb begin
        read_mux = '0;
        if (hit) begin
            case (offset)
                OFF_STATUS: begin
                    read_mux[ST_TX_RDY] = uart_tx_ready && !tx_valid_reg;
                    read_mux[ST_RX_VLD] = uart_rx_valid;
                end
                OFF_RX:   read_mux = uart_rx_valid ? {24'b0, uart_rx_data} : 32'b0;
                OFF_CYC:  read_mux = 32'(cyc_count);
                OFF_INST: read_mux = 32'(inst_count);
`ifdef MMIO_BRANCH_CTR_EN
                OFF_BR:   read_mux = 32'(br_count);
`endif
                default:  read_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= read_mux;
        end
    end

    // A store while a byte is pending is dropped, even if the pending byte
    // hands off on this very edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
        end else if (tx_valid_reg) begin
            if (uart_tx_ready) begin
                tx_valid_reg <= 1'b0;
            end
        end else if (tx_push) begin
            tx_valid_reg <= 1'b1;
            tx_data_reg  <= wdata[7:0];
        end
    end

    assign rdata         = rdata_reg;
    assign uart_tx_valid = tx_valid_reg;
    assign uart_tx_data  = tx_data_reg;

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed vector table, hand-written
// TX/counter sequences and randomized traffic against a behavioural model.
module tb_mmio_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        re;
    logic [31:0] rdata;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic        inst_retire;
    logic        branch_retire;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mmio_responder dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .wdata         (wdata),
        .we            (we),
        .re            (re),
        .rdata         (rdata),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .inst_retire   (inst_retire),
        .branch_retire (branch_retire)
    );

    // Behavioural model state
    logic [31:0] m_cyc, m_inst, m_br, m_rdata;
    logic        m_txv;
    logic [7:0]  m_txb;
    logic [7:0]  m_sent[$];
    logic [7:0]  dut_sent[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic rxv,
                                               input logic [7:0] rxd, input logic txr);
        if (a[31:8] != 24'h800000) return 32'h0;
        case (a[7:0])
            8'h00:   return {30'b0, rxv, txr & ~m_txv};
            8'h04:   return rxv ? {24'b0, rxd} : 32'h0;
            8'h10:   return m_cyc;
            8'h14:   return m_inst;
`ifdef MMIO_BRANCH_CTR_EN
            8'h1C:   return m_br;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        addr = '0; wdata = '0; we = '0; re = 1'b0;
        uart_rx_data = '0; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;
        inst_retire = 1'b0; branch_retire = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_rdata", rdata, 32'h0);
        check("reset_tx_valid", {31'b0, uart_tx_valid}, 32'h0);
        check("reset_tx_data", {24'b0, uart_tx_data}, 32'h0);
        check("reset_rx_ready", {31'b0, uart_rx_ready}, 32'h0);
        rst = 1'b0;
        m_cyc = 0; m_inst = 0; m_br = 0; m_rdata = 0; m_txv = 1'b0; m_txb = 8'h00;
        $display("reset done");
    endtask

    // One request cycle: drive, check the combinational pop, clock, check results.
    task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] w,
                        input logic r, input logic rxv, input logic [7:0] rxd,
                        input logic txr, input logic ir, input logic br);
        logic        hit_s, st, clr;
        logic [31:0] rd_exp;
        addr = a; wdata = wd; we = w; re = r;
        uart_rx_valid = rxv; uart_rx_data = rxd; uart_tx_ready = txr;
        inst_retire = ir; branch_retire = br;
        #2;
        hit_s = (a[31:8] == 24'h800000);
        check("rx_ready", {31'b0, uart_rx_ready},
              {31'b0, r && hit_s && a[7:0] == 8'h04 && rxv});
        rd_exp = model_read(a, rxv, rxd, txr);
        if (uart_tx_valid && txr) dut_sent.push_back(uart_tx_data);
        @(posedge clk);
        st  = hit_s && (w != 4'b0);
        clr = st && a[7:0] == 8'h18;
        if (r) m_rdata = rd_exp;
        if (m_txv) begin
            if (txr) begin
                m_sent.push_back(m_txb);
                m_txv = 1'b0;
            end
        end else if (st && a[7:0] == 8'h08 && w[0]) begin
            m_txv = 1'b1;
            m_txb = wd[7:0];
        end
        m_cyc  = clr ? 32'h0 : m_cyc + 32'h1;
        m_inst = clr ? 32'h0 : m_inst + {31'b0, ir};
        m_br   = clr ? 32'h0 : m_br + {31'b0, br};
        #1;
        check("rdata", rdata, m_rdata);
        check("tx_valid", {31'b0, uart_tx_valid}, {31'b0, m_txv});
        check("tx_data", {24'b0, uart_tx_data}, {24'b0, m_txb});
        $display("txn addr=%08h we=%h re=%0d wdata=%08h -> rdata=%08h tx_valid=%0d tx_data=%02h",
                 a, w, r, wd, rdata, uart_tx_valid, uart_tx_data);
    endtask

    task automatic idle(input logic txr, input logic ir);
        step(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 8'h00, txr, ir, 1'b0);
    endtask

    task automatic load(input logic [31:0] a);
        step(a, 32'h0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] wd, input logic txr, input logic ir);
        step(a, wd, 4'hF, 1'b0, 1'b0, 8'h00, txr, ir, 1'b0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic        r;
        logic        rxv;
        logic [7:0]  rxd;
        logic        txr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    logic [7:0] offs[9];

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{32'h8000_0000, 1'b1, 1'b1, 8'h00, 1'b1, 32'h3};
        vecs[1]  = '{32'h8000_0040, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0};
        vecs[2]  = '{32'h9000_0000, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0};
        vecs[3]  = '{32'h8000_0004, 1'b1, 1'b1, 8'h5A, 1'b0, 32'h5A};
        vecs[4]  = '{32'h8000_0000, 1'b0, 1'b1, 8'h00, 1'b1, 32'h5A};
        vecs[5]  = '{32'h8000_0004, 1'b1, 1'b0, 8'h5A, 1'b0, 32'h0};
        vecs[6]  = '{32'h8000_0008, 1'b1, 1'b1, 8'h11, 1'b1, 32'h0};
        vecs[7]  = '{32'h8000_0000, 1'b1, 1'b0, 8'h00, 1'b1, 32'h1};
        vecs[8]  = '{32'h8000_0000, 1'b1, 1'b1, 8'h00, 1'b0, 32'h2};
        vecs[9]  = '{32'h8000_001C, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0};
        vecs[10] = '{32'h8000_0014, 1'b1, 1'b0, 8'h00, 1'b0, 32'h0};
        offs = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h0C, 8'h40};

        @(posedge clk);
        #1;

        // Cycle counter after 10 idle cycles, instruction counter with no retires
        do_reset();
        for (int i = 0; i < 10; i++) idle(1'b0, 1'b0);
        load(32'h8000_0010);
        check("cyc_after_10", rdata, 32'd10);
        load(32'h8000_0014);
        check("inst_idle", rdata, 32'd0);

        // Vector table
        do_reset();
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].a, 32'h0, 4'h0, vecs[i].r, vecs[i].rxv, vecs[i].rxd,
                 vecs[i].txr, 1'b0, 1'b0);
            check($sformatf("vec%0d", i), rdata, vecs[i].exp);
        end

        // TX holding register: hold, drop while busy, single send
        do_reset();
        dut_sent.delete();
        m_sent.delete();
        store(32'h8000_0008, 32'h41, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle(1'b0, 1'b0);
            check("tx_hold_data", {24'b0, uart_tx_data}, 32'h41);
        end
        store(32'h8000_0008, 32'h42, 1'b0, 1'b0);
        idle(1'b1, 1'b0);
        check("tx_cleared", {31'b0, uart_tx_valid}, 32'h0);
        check("tx_sent_count", dut_sent.size(), 32'd1);
        if (dut_sent.size() == 1) check("tx_sent_byte", {24'b0, dut_sent[0]}, 32'h41);
        // Store on the handshake edge is dropped
        store(32'h8000_0008, 32'h43, 1'b0, 1'b0);
        store(32'h8000_0008, 32'h44, 1'b1, 1'b0);
        check("tx_same_edge_drop", {31'b0, uart_tx_valid}, 32'h0);
        idle(1'b1, 1'b0);
        check("tx_sent_count2", dut_sent.size(), 32'd2);
        // Pending byte discarded by reset
        store(32'h8000_0008, 32'h55, 1'b0, 1'b0);
        do_reset();

        // Counter clear beats a same-edge retire; cycle counter resumes
        for (int i = 0; i < 7; i++) idle(1'b0, 1'b1);
        load(32'h8000_0014);
        check("inst_7", rdata, 32'd7);
        store(32'h8000_0018, 32'h0, 1'b0, 1'b1);
        load(32'h8000_0010);
        check("cyc_cleared", rdata, 32'd0);
        load(32'h8000_0014);
        check("inst_cleared", rdata, 32'd0);
        load(32'h8000_0010);
        check("cyc_resumed", rdata, 32'd2);

        // Branch counter
        for (int i = 0; i < 3; i++) step(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        load(32'h8000_001C);
`ifdef MMIO_BRANCH_CTR_EN
        check("br_3", rdata, 32'd3);
`else
        check("br_absent", rdata, 32'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            logic [3:0]  w;
            int          k;
            k = $urandom_range(0, 19);
            a = (k == 19) ? 32'h9000_0000 | 32'($urandom_range(0, 255))
                          : {24'h800000, offs[k % 9]};
            case ($urandom_range(0, 5))
                0:       w = 4'hF;
                1:       w = 4'h1;
                2:       w = 4'h2;
                default: w = 4'h0;
            endcase
            step(a, $urandom, w, ($urandom_range(0, 2) != 0), 1'($urandom),
                 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        check("sent_count_total", dut_sent.size(), m_sent.size());
        for (int i = 0; i < m_sent.size() && i < dut_sent.size(); i++)
            check("sent_byte", {24'b0, dut_sent[i]}, {24'b0, m_sent[i]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
